// File: rtl/pinmux_filt_mux.sv
// pinmux_filt_mux
// Pin multiplexer between peripheral I/O and MIO pads, with pad-input
// synchronisation, per-pad glitch filtering, a single-pad wakeup detector
// and a valid/ready configuration port with a sticky lock.
//
// Ports:
//   clk_i, rst_i               clock, asynchronous active-high reset
//   periph_to_mio_i/_oe_i      peripheral output data / enables
//   mio_to_periph_o            selected, filtered pad data to peripherals
//   mio_out_o / mio_oe_o       pad output data / enables
//   mio_in_i                   raw asynchronous pad inputs
//   cfg_valid_i/cfg_ready_o    config write handshake
//   cfg_target_i/idx_i/data_i  config write target, table index, data
//   cfg_ack_o / cfg_err_o      one-cycle completion / rejection pulses
//   cfg_locked_o               config lock state
//   wkup_o / wkup_clr_i        sticky wakeup flag and its clear
module pinmux_filt_mux #(
  parameter int NPeriphIn  = 32,
  parameter int NPeriphOut = 32,
  parameter int NMioPads   = 32,
  parameter int FiltCntW   = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NPeriphOut-1:0] periph_to_mio_i,
  input  logic [NPeriphOut-1:0] periph_to_mio_oe_i,
  output logic [NPeriphIn-1:0]  mio_to_periph_o,
  output logic [NMioPads-1:0]   mio_out_o,
  output logic [NMioPads-1:0]   mio_oe_o,
  input  logic [NMioPads-1:0]   mio_in_i,
  input  logic                  cfg_valid_i,
  output logic                  cfg_ready_o,
  input  logic [2:0]            cfg_target_i,
  input  logic [7:0]            cfg_idx_i,
  input  logic [31:0]           cfg_data_i,
  output logic                  cfg_ack_o,
  output logic                  cfg_err_o,
  output logic                  cfg_locked_o,
  output logic                  wkup_o,
  input  logic                  wkup_clr_i
);

  localparam int InSelW  = $clog2(NMioPads + 2);
  localparam int OutSelW = $clog2(NPeriphOut + 3);
  localparam int PadW    = (NMioPads > 1) ? $clog2(NMioPads) : 1;
  localparam int InIdxW  = (NPeriphIn > 1) ? $clog2(NPeriphIn) : 1;

  localparam logic [31:0] InIdxLimit  = 32'(NPeriphIn);
  localparam logic [31:0] PadLimit    = 32'(NMioPads);
  localparam logic [31:0] InSelLimit  = 32'(NMioPads + 2);
  localparam logic [31:0] OutSelLimit = 32'(NPeriphOut + 3);

  // ---------------------------------------------------------------------------
  // Config decode
  // ---------------------------------------------------------------------------
  logic                ready_q, ack_q, err_q, locked_q;
  logic [FiltCntW-1:0] thresh_q;
  logic                cfg_acc, cfg_bad, wr_ok;
  logic                we_insel, we_outsel, we_filt, we_thresh, we_wk, we_lock;
  logic [31:0]         idx_ext, pad_ext;

  assign idx_ext = {24'd0, cfg_idx_i};
  assign pad_ext = {24'd0, cfg_data_i[15:8]};
  assign cfg_acc = cfg_valid_i & ready_q;

  always_comb begin
    cfg_bad = 1'b0;
    if (locked_q) begin
      cfg_bad = 1'b1;
    end else begin
      case (cfg_target_i)
        3'd0:    cfg_bad = (idx_ext >= InIdxLimit) || (cfg_data_i >= InSelLimit);
        3'd1:    cfg_bad = (idx_ext >= PadLimit) || (cfg_data_i >= OutSelLimit);
        3'd2:    cfg_bad = (idx_ext >= PadLimit);
        3'd3:    cfg_bad = 1'b0;
        3'd4:    cfg_bad = (pad_ext >= PadLimit);
        3'd5:    cfg_bad = 1'b0;
        default: cfg_bad = 1'b1;
      endcase
    end
  end

  assign wr_ok     = cfg_acc & ~cfg_bad;
  assign we_insel  = wr_ok && (cfg_target_i == 3'd0);
  assign we_outsel = wr_ok && (cfg_target_i == 3'd1);
  assign we_filt   = wr_ok && (cfg_target_i == 3'd2);
  assign we_thresh = wr_ok && (cfg_target_i == 3'd3);
  assign we_wk     = wr_ok && (cfg_target_i == 3'd4);
  assign we_lock   = wr_ok && (cfg_target_i == 3'd5);

  // ---------------------------------------------------------------------------
  // Pad input path: synchroniser + glitch filter, one instance per pad
  // ---------------------------------------------------------------------------
  logic [NMioPads-1:0] filt_vec;

  for (genvar gi = 0; gi < NMioPads; gi++) begin : g_pad
    logic                meta_q, sync_q, f_q, f_d, filt_en_q;
    logic [FiltCntW-1:0] c_q, c_d;

    always_comb begin
      f_d = f_q;
      c_d = '0;
      if (!filt_en_q) begin
        f_d = sync_q;
      end else if (sync_q != f_q) begin
        if (c_q == thresh_q) begin
          f_d = sync_q;
        end else begin
          c_d = c_q + 1'b1;
        end
      end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        meta_q    <= 1'b0;
        sync_q    <= 1'b0;
        f_q       <= 1'b0;
        c_q       <= '0;
        filt_en_q <= 1'b0;
      end else begin
        meta_q <= mio_in_i[gi];
        sync_q <= meta_q;
        f_q    <= f_d;
        c_q    <= c_d;
        if (we_filt && (cfg_idx_i[PadW-1:0] == PadW'(gi))) begin
          filt_en_q <= cfg_data_i[0];
        end
      end
    end

    assign filt_vec[gi] = f_q;
  end

  // ---------------------------------------------------------------------------
  // Input mux: selector 0/1 pick constants, 2+k picks filtered pad k
  // ---------------------------------------------------------------------------
  logic [NMioPads+1:0] in_src;
  assign in_src = {filt_vec, 1'b1, 1'b0};

  for (genvar gi = 0; gi < NPeriphIn; gi++) begin : g_insel
    logic [InSelW-1:0] insel_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        insel_q <= '0;
      end else if (we_insel && (cfg_idx_i[InIdxW-1:0] == InIdxW'(gi))) begin
        insel_q <= cfg_data_i[InSelW-1:0];
      end
    end

    assign mio_to_periph_o[gi] = in_src[insel_q];
  end

  // ---------------------------------------------------------------------------
  // Output mux: 0 drive low, 1 drive high, 2 high-Z, 3+k peripheral k
  // ---------------------------------------------------------------------------
  logic [NPeriphOut+2:0] out_src, oe_src;
  assign out_src = {periph_to_mio_i,    1'b0, 1'b1, 1'b0};
  assign oe_src  = {periph_to_mio_oe_i, 1'b0, 1'b1, 1'b1};

  for (genvar gi = 0; gi < NMioPads; gi++) begin : g_outsel
    logic [OutSelW-1:0] outsel_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        outsel_q <= OutSelW'(2);
      end else if (we_outsel && (cfg_idx_i[PadW-1:0] == PadW'(gi))) begin
        outsel_q <= cfg_data_i[OutSelW-1:0];
      end
    end

    assign mio_out_o[gi] = out_src[outsel_q];
    assign mio_oe_o[gi]  = oe_src[outsel_q];
  end

  // ---------------------------------------------------------------------------
  // Wakeup detector on one selected filtered pad
  // ---------------------------------------------------------------------------
  logic            wk_en_q, wk_prev_q, wkup_q, wk_sel, wk_hit;
  logic [1:0]      wk_mode_q;
  logic [PadW-1:0] wk_pad_q;

  assign wk_sel = filt_vec[wk_pad_q];

  always_comb begin
    wk_hit = 1'b0;
    case (wk_mode_q)
      2'd0:    wk_hit = wk_sel & ~wk_prev_q;
      2'd1:    wk_hit = ~wk_sel & wk_prev_q;
      2'd2:    wk_hit = wk_sel ^ wk_prev_q;
      default: wk_hit = wk_sel;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ready_q   <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      locked_q  <= 1'b0;
      thresh_q  <= '0;
      wk_en_q   <= 1'b0;
      wk_mode_q <= 2'd0;
      wk_pad_q  <= '0;
      wk_prev_q <= 1'b0;
      wkup_q    <= 1'b0;
    end else begin
      ready_q <= 1'b1;
      ack_q   <= cfg_acc;
      err_q   <= cfg_acc & cfg_bad;
      if (we_lock && cfg_data_i[0]) begin
        locked_q <= 1'b1;
      end
      if (we_thresh) begin
        thresh_q <= cfg_data_i[FiltCntW-1:0];
      end
      // Reload the edge history from the newly chosen pad so a reconfig
      // never looks like an edge.
      if (we_wk) begin
        wk_en_q   <= cfg_data_i[0];
        wk_mode_q <= cfg_data_i[2:1];
        wk_pad_q  <= cfg_data_i[PadW+7:8];
        wk_prev_q <= filt_vec[cfg_data_i[PadW+7:8]];
      end else begin
        wk_prev_q <= wk_sel;
      end
      // Set wins over clear.
      if (wk_en_q && wk_hit) begin
        wkup_q <= 1'b1;
      end else if (wkup_clr_i) begin
        wkup_q <= 1'b0;
      end
    end
  end

  assign cfg_ready_o  = ready_q;
  assign cfg_ack_o    = ack_q;
  assign cfg_err_o    = err_q;
  assign cfg_locked_o = locked_q;
  assign wkup_o       = wkup_q;

endmodule

// File: tb/tb_pinmux_filt_mux.sv
// Directed testbench for pinmux_filt_mux with default parameters.
module tb_pinmux_filt_mux;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] periph_to_mio, periph_to_mio_oe;
  logic [31:0] mio_to_periph, mio_out, mio_oe;
  logic [31:0] mio_in;
  logic        cfg_valid, cfg_ready, cfg_ack, cfg_err, cfg_locked;
  logic [2:0]  cfg_target;
  logic [7:0]  cfg_idx;
  logic [31:0] cfg_data;
  logic        wkup, wkup_clr;

  int checks = 0;
  int failures = 0;
  logic seen;

  always #5 clk = ~clk;

  pinmux_filt_mux dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .periph_to_mio_i    (periph_to_mio),
    .periph_to_mio_oe_i (periph_to_mio_oe),
    .mio_to_periph_o    (mio_to_periph),
    .mio_out_o          (mio_out),
    .mio_oe_o           (mio_oe),
    .mio_in_i           (mio_in),
    .cfg_valid_i        (cfg_valid),
    .cfg_ready_o        (cfg_ready),
    .cfg_target_i       (cfg_target),
    .cfg_idx_i          (cfg_idx),
    .cfg_data_i         (cfg_data),
    .cfg_ack_o          (cfg_ack),
    .cfg_err_o          (cfg_err),
    .cfg_locked_o       (cfg_locked),
    .wkup_o             (wkup),
    .wkup_clr_i         (wkup_clr)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cfg_wr(input logic [2:0] t, input logic [7:0] idx, input logic [31:0] d,
                        input logic exp_err, input string tag);
    cfg_valid  = 1'b1;
    cfg_target = t;
    cfg_idx    = idx;
    cfg_data   = d;
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
    $display("cfg write %s target=%0d idx=%0d data=0x%0h ack=%0b err=%0b",
             tag, t, idx, d, cfg_ack, cfg_err);
    check_val({tag, "_ack"}, {31'd0, cfg_ack}, 32'd1);
    check_val({tag, "_err"}, {31'd0, cfg_err}, {31'd0, exp_err});
  endtask

  initial begin
    rst = 1'b1;
    periph_to_mio = '0;
    periph_to_mio_oe = '0;
    mio_in = '0;
    cfg_valid = 1'b0;
    cfg_target = '0;
    cfg_idx = '0;
    cfg_data = '0;
    wkup_clr = 1'b0;

    // 1. Reset state
    #12;
    check_val("rst_ready", {31'd0, cfg_ready}, 32'd0);
    check_val("rst_oe", mio_oe, 32'd0);
    check_val("rst_out", mio_out, 32'd0);
    check_val("rst_periph", mio_to_periph, 32'd0);
    check_val("rst_wkup", {31'd0, wkup}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check_val("rel_ready_before_edge", {31'd0, cfg_ready}, 32'd0);
    tick(1);
    check_val("rel_ready", {31'd0, cfg_ready}, 32'd1);
    check_val("rel_oe", mio_oe, 32'd0);

    // 2. Unfiltered latency: pad 5 -> periph 4
    cfg_wr(3'd0, 8'd4, 32'd7, 1'b0, "insel4_pad5");
    tick(1);
    check_val("ack_one_cycle", {30'd0, cfg_ack, cfg_err}, 32'd0);
    mio_in[5] = 1'b1;
    tick(2);
    check_val("lat_edge2", {31'd0, mio_to_periph[4]}, 32'd0);
    tick(1);
    check_val("lat_edge3", {31'd0, mio_to_periph[4]}, 32'd1);
    mio_in[5] = 1'b0;
    tick(4);
    check_val("lat_fall", {31'd0, mio_to_periph[4]}, 32'd0);

    // 3. Glitch filter, thresh = 3
    cfg_wr(3'd3, 8'd0, 32'd3, 1'b0, "thresh3");
    cfg_wr(3'd2, 8'd5, 32'd1, 1'b0, "filt_en5");
    mio_in[5] = 1'b1;
    tick(3);
    mio_in[5] = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      seen = seen | mio_to_periph[4];
    end
    check_val("filt_short_pulse", {31'd0, seen}, 32'd0);
    mio_in[5] = 1'b1;
    tick(4);
    mio_in[5] = 1'b0;
    tick(1);
    check_val("filt_edge5", {31'd0, mio_to_periph[4]}, 32'd0);
    tick(1);
    check_val("filt_edge6", {31'd0, mio_to_periph[4]}, 32'd1);
    tick(3);
    check_val("filt_edge9", {31'd0, mio_to_periph[4]}, 32'd1);
    tick(1);
    check_val("filt_edge10", {31'd0, mio_to_periph[4]}, 32'd0);
    cfg_wr(3'd0, 8'd4, 32'd1, 1'b0, "insel4_const1");
    check_val("insel_const1", {31'd0, mio_to_periph[4]}, 32'd1);
    check_val("insel_default0", {31'd0, mio_to_periph[5]}, 32'd0);

    // 4. Output mux
    periph_to_mio[9] = 1'b1;
    periph_to_mio_oe[9] = 1'b0;
    cfg_wr(3'd1, 8'd0, 32'd12, 1'b0, "outsel0_p9");
    check_val("out0_p9", {30'd0, mio_out[0], mio_oe[0]}, 32'b10);
    periph_to_mio[9] = 1'b0;
    periph_to_mio_oe[9] = 1'b1;
    #1;
    check_val("out0_p9_comb", {30'd0, mio_out[0], mio_oe[0]}, 32'b01);
    cfg_wr(3'd1, 8'd0, 32'd2, 1'b0, "outsel0_hiz");
    check_val("out0_hiz", {30'd0, mio_out[0], mio_oe[0]}, 32'b00);
    cfg_wr(3'd1, 8'd1, 32'd0, 1'b0, "outsel1_low");
    check_val("out1_low", {30'd0, mio_out[1], mio_oe[1]}, 32'b01);
    cfg_wr(3'd1, 8'd2, 32'd1, 1'b0, "outsel2_high");
    check_val("out2_high", {30'd0, mio_out[2], mio_oe[2]}, 32'b11);
    periph_to_mio[31] = 1'b1;
    periph_to_mio_oe[31] = 1'b1;
    cfg_wr(3'd1, 8'd31, 32'd34, 1'b0, "outsel31_p31");
    check_val("out31_p31", {30'd0, mio_out[31], mio_oe[31]}, 32'b11);

    // 6. Wakeup on pad 3
    cfg_wr(3'd4, 8'd0, 32'h2001, 1'b1, "wk_pad_oob");
    cfg_wr(3'd4, 8'd0, 32'h0301, 1'b0, "wk_rise3");
    check_val("wk_idle", {31'd0, wkup}, 32'd0);
    mio_in[3] = 1'b1;
    tick(3);
    check_val("wk_edge3", {31'd0, wkup}, 32'd0);
    tick(1);
    check_val("wk_edge4", {31'd0, wkup}, 32'd1);
    tick(3);
    check_val("wk_sticky", {31'd0, wkup}, 32'd1);
    cfg_wr(3'd4, 8'd0, 32'h0307, 1'b0, "wk_level3");
    wkup_clr = 1'b1;
    tick(1);
    wkup_clr = 1'b0;
    check_val("wk_set_beats_clr", {31'd0, wkup}, 32'd1);
    cfg_wr(3'd4, 8'd0, 32'h0306, 1'b0, "wk_disable");
    tick(1);
    check_val("wk_disable_keeps", {31'd0, wkup}, 32'd1);
    cfg_wr(3'd4, 8'd0, 32'h0303, 1'b0, "wk_fall3");
    wkup_clr = 1'b1;
    tick(1);
    wkup_clr = 1'b0;
    check_val("wk_cleared", {31'd0, wkup}, 32'd0);
    mio_in[3] = 1'b0;
    tick(3);
    check_val("wk_fall_edge3", {31'd0, wkup}, 32'd0);
    tick(1);
    check_val("wk_fall_edge4", {31'd0, wkup}, 32'd1);

    // 5. Error writes and lock
    cfg_wr(3'd0, 8'd32, 32'd0, 1'b1, "insel_idx_oob");
    check_val("insel_unchanged", {31'd0, mio_to_periph[4]}, 32'd1);
    cfg_wr(3'd0, 8'd4, 32'd34, 1'b1, "insel_data_oob");
    check_val("insel_unchanged2", {31'd0, mio_to_periph[4]}, 32'd1);
    cfg_wr(3'd0, 8'd6, 32'd33, 1'b0, "insel_data_max");
    cfg_wr(3'd1, 8'd32, 32'd0, 1'b1, "outsel_idx_oob");
    cfg_wr(3'd1, 8'd0, 32'd35, 1'b1, "outsel_data_oob");
    check_val("outsel_unchanged", {30'd0, mio_out[0], mio_oe[0]}, 32'b00);
    cfg_wr(3'd2, 8'd32, 32'd1, 1'b1, "filt_idx_oob");
    cfg_wr(3'd6, 8'd0, 32'd0, 1'b1, "target6");
    cfg_wr(3'd7, 8'd0, 32'd0, 1'b1, "target7");
    cfg_wr(3'd5, 8'd0, 32'd0, 1'b0, "lock_data0");
    check_val("lock_not_set", {31'd0, cfg_locked}, 32'd0);
    cfg_wr(3'd5, 8'd0, 32'd1, 1'b0, "lock_set");
    check_val("locked", {31'd0, cfg_locked}, 32'd1);
    cfg_wr(3'd1, 8'd0, 32'd1, 1'b1, "outsel_locked");
    check_val("locked_unchanged", {30'd0, mio_out[0], mio_oe[0]}, 32'b00);
    cfg_wr(3'd0, 8'd4, 32'd0, 1'b1, "insel_locked");
    check_val("locked_insel_kept", {31'd0, mio_to_periph[4]}, 32'd1);

    // Reset mid-operation kills a pending pulse
    cfg_valid = 1'b1;
    cfg_target = 3'd6;
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
    check_val("pre_rst_pulse", {30'd0, cfg_ack, cfg_err}, 32'b11);
    rst = 1'b1;
    #1;
    check_val("async_rst_pulse", {30'd0, cfg_ack, cfg_err}, 32'b00);
    check_val("async_rst_lock", {31'd0, cfg_locked}, 32'd0);
    check_val("async_rst_ready", {31'd0, cfg_ready}, 32'd0);
    check_val("async_rst_wkup", {31'd0, wkup}, 32'd0);
    check_val("async_rst_periph", mio_to_periph, 32'd0);
    check_val("async_rst_oe", mio_oe, 32'd0);
    #10;
    rst = 1'b0;
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pinmux_filt_mux.md
Name: pinmux_filt_mux

Overview:
Parametrised next-generation pin multiplexer between peripheral I/O and MIO pads.
- Adds pad-input synchronisation, per-pad glitch filtering and a single-pad wakeup detector.
- Adds a valid/ready configuration port with a sticky lock.
- Sits between peripheral blocks and the pad ring. Replaces fixed-width mux instances.

Parameters:
NPeriphIn, 32, number of peripheral inputs (mio_to_periph_o width)
NPeriphOut, 32, number of peripheral outputs (periph_to_mio_* width)
NMioPads, 32, number of MIO pads; must be <= 256
FiltCntW, 4, glitch-filter counter and threshold width

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
periph_to_mio_i  in  NPeriphOut  peripheral output data
periph_to_mio_oe_i  in  NPeriphOut  peripheral output enables
mio_to_periph_o  out  NPeriphIn  muxed, filtered pad data to peripherals
mio_out_o  out  NMioPads  pad output data
mio_oe_o  out  NMioPads  pad output enables
mio_in_i  in  NMioPads  raw asynchronous pad inputs
cfg_valid_i  in  1  config write request
cfg_ready_o  out  1  config write can be accepted
cfg_target_i  in  3  config target select
cfg_idx_i  in  8  table index
cfg_data_i  in  32  write data
cfg_ack_o  out  1  one-cycle pulse, write completed
cfg_err_o  out  1  one-cycle pulse, coincident with ack, write rejected
cfg_locked_o  out  1  config locked
wkup_o  out  1  sticky wakeup flag
wkup_clr_i  in  1  clear wakeup flag

Behaviour:
Reset values
- All outputs 0 while rst_i is high, including cfg_ready_o.
- insel[] = 0; outsel[] = 2 (pads high-Z); filt_en = 0; thresh = 0; wakeup disabled; lock = 0.
- cfg_ready_o = 1 from the first edge after reset release.

Pad input path
- Per pad: 2-flop synchroniser producing s[k], then filter state f[k] and counter c[k].
- Filter disabled: f <= s, c <= 0.
- Filter enabled:
  - if s == f: c <= 0
  - else if c == thresh: f <= s, c <= 0
  - else: c <= c + 1
- A level must persist thresh+1 consecutive synchronised cycles to propagate.
- Changing thresh or filt_en mid-count takes effect at the next edge; no counter reset.

Input mux (combinational from f and insel)
- insel[i]: 0 -> const 0; 1 -> const 1; 2+k -> f[k].
- Latency, pad edge to mio_to_periph_o: 3 + thresh clock edges (3 when filter disabled).

Output mux (combinational, 0 latency), per pad outsel[p]:
- 0: out 0, oe 1
- 1: out 1, oe 1
- 2: out 0, oe 0
- 3+k: out = periph_to_mio_i[k], oe = periph_to_mio_oe_i[k]

Config port
- Write accepted when cfg_valid_i && cfg_ready_o.
- Table update and ack/err pulse occur at the accepting edge; visible the next cycle.
- Targets:
  - 0: insel[idx], idx < NPeriphIn; data >= NMioPads+2 -> err
  - 1: outsel[idx], idx < NMioPads; data >= NPeriphOut+3 -> err
  - 2: filt_en[idx] = data[0]
  - 3: thresh = data[FiltCntW-1:0]
  - 4: wakeup config: data[0] = en; data[2:1] = mode (0 rise, 1 fall, 2 any edge, 3 level-high); data[15:8] = pad; pad >= NMioPads -> err
  - 5: data[0] = 1 sets lock
  - 6, 7: err
- Any out-of-range idx -> err. Any write while locked -> err.
- On err: no state change, ack still pulses.
- Lock is cleared only by reset.

Wakeup
- Monitors f[pad]; prev register is reloaded with f[pad] on every target-4 write, so there is no spurious edge.
- When enabled and the mode condition is true, wkup_o is set next edge and stays set.
- wkup_clr_i clears wkup_o; a simultaneous set and clear leaves it set.
- Disabling wakeup does not clear wkup_o.

Reset mid-operation
- All state returns to reset values asynchronously, including a pending ack/err pulse.

Test Plan:
1. Reset, outsel untouched -> mio_oe_o = 0, mio_out_o = 0, mio_to_periph_o = 0, cfg_ready_o = 1 one edge after release.
2. Write insel[4] = 7, filter off, toggle mio_in_i[5] 0 -> 1 -> mio_to_periph_o[4] rises exactly 3 edges later; insel[4] = 1 -> constant 1.
3. thresh = 3, filt_en[5] = 1; 3-cycle high pulse on pad 5 -> output stays 0; 4-cycle pulse -> output rises at edge 6 and falls correspondingly.
4. outsel[0] = 3+9, periph_to_mio_i[9] = 1, oe[9] = 0 -> mio_out_o[0] = 1, mio_oe_o[0] = 0 same cycle; outsel[0] = 2 -> both 0.
5. Error writes: insel idx = NPeriphIn -> ack + err, no change. Target 5 data 1, then outsel write -> err, cfg_locked_o = 1, table unchanged.
6. Wakeup rise on pad 3: pad rises -> wkup_o = 1 and stays; wkup_clr_i with a level-high mode still active -> wkup_o stays 1; switch to fall mode, clear -> 0.
